upc_scanner: RTL and testbench
==============================

# upc_scanner

Front-end capture stage for the UPC item display. It synchronizes and debounces the raw scan pushbutton and synchronizes the three UPC slide switches. On each clean press it latches the switch value into a held 3-bit code that drives the downstream 7-segment UPC decoder's `bcd` input. Codes the decoder does not define (2, 7) are rejected and flagged, so the decoder only ever sees legal codes 0, 1, 3, 4, 5 and 6.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 250000 (5 ms at 50 MHz): number of consecutive stable clock edges required to accept a press or a release; legal range ≥ 2.
- `CNT_W`, default `$clog2(DEBOUNCE_CYCLES)`: debounce counter width.

Ports:
- `clk`  in  1  single system clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `sw`  in  3  raw UPC switches, asynchronous to `clk`.
- `key_n`  in  1  raw scan pushbutton, active-low, asynchronous, bouncy.
- `bcd`  out  3  held UPC code; connects directly to the display decoder `bcd`.
- `valid`  out  1  high once any legal code has been captured since reset.
- `err`  out  1  high while the most recent press carried an illegal code.
- `scan_count`  out  8  count of accepted (legal) scans.

## Operation
- `key_n` and `sw` each pass through a 2-flop synchronizer. The synchronized signals are `key_s` and `sw_s`.
- The FSM has four states, and `cnt` is cleared on every state change:
  - **IDLE**: if `key_s`==0, go to PRESS_WAIT.
  - **PRESS_WAIT**: if `key_s`==1, return to IDLE. Otherwise increment `cnt`. On the edge where `cnt`==DEBOUNCE_CYCLES-1 and `key_s`==0, capture and go to HELD.
  - **HELD**: if `key_s`==1, go to RELEASE_WAIT.
  - **RELEASE_WAIT**: if `key_s`==0, return to HELD. Otherwise increment `cnt`. At `cnt`==DEBOUNCE_CYCLES-1 with `key_s`==1, go to IDLE.
- Capture behaviour:
  - If `sw_s` is in {0,1,3,4,5,6}: `bcd`<=`sw_s`, `valid`<=1, `err`<=0, `scan_count`<=`scan_count`+1.
  - If `sw_s` is in {2,7}: `bcd` unchanged, `valid` unchanged, `err`<=1, `scan_count` unchanged.
- There is exactly one capture per debounced press. Switch changes while in HELD, RELEASE_WAIT or IDLE have no effect on `bcd`.
- `scan_count` wraps 255→0 (see Configuration).
- All outputs are registered. `bcd` never takes values 2 or 7.

## Timing
- Reset values: `bcd`=0, `valid`=0, `err`=0, `scan_count`=0, FSM=IDLE, `cnt`=0, synchronizer flops=1 for `key_n` and 0 for `sw`.
- Reset takes effect on the first rising edge with `reset`=1 and overrides all other activity, including reset mid-PRESS_WAIT or mid-RELEASE_WAIT.
- A key still held low when `reset` deasserts is treated as a new press and is captured after the debounce period.
- Press latency:
  - `key_n` low before edge 0 gives `key_s`=0 after edge 1.
  - The FSM enters PRESS_WAIT at edge 2.
  - `bcd`, `err`, `valid` and `scan_count` update at edge 2+DEBOUNCE_CYCLES, provided `key_n` stays low throughout.
- `sw` must be stable for at least 2 cycles before the capture edge. The sampled value is `sw_s` at the capture edge.
- Any single-cycle `key_n` glitch restarts the relevant debounce window. A press shorter than DEBOUNCE_CYCLES synchronized cycles produces no capture.
- A new press cannot be recognised until RELEASE_WAIT completes, i.e. after DEBOUNCE_CYCLES stable-high edges.

## Configuration
- Macro: `UPC_SCANNER_SAT_EN`.
- Defined: `scan_count` saturates at 255; further legal captures leave it at 255, while still updating `bcd`, `valid` and `err`.
- Undefined: `scan_count` wraps modulo 256.
- The macro has no other effect.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4.
- **Reset:** hold `reset`=1 for 1 edge with `key_n`=0, `sw`=5 → `bcd`=0, `valid`=0, `err`=0, `scan_count`=0 immediately after that edge.
- **Clean press:** `sw`=3, then `key_n` low for 20 cycles → `bcd`=3, `valid`=1, `scan_count`=1 exactly at edge 6 after the fall. No further change while held; change `sw` to 6 during the hold → `bcd` stays 3.
- **Bounce:** `key_n` toggles low 3 cycles / high 1 cycle ×10 → no capture; `bcd`, `valid`, `scan_count` unchanged. Release bounce of low 2 cycles inside RELEASE_WAIT → no second capture.
- **Illegal code:** after `bcd`=3, press with `sw`=7 → `bcd`=3, `err`=1, `scan_count` unchanged. Then press with `sw`=5 → `bcd`=5, `err`=0, `scan_count`=+1. Repeat with `sw`=2 → `err`=1.
- **Reset mid-press:** assert `reset` 2 cycles into PRESS_WAIT → all outputs are at reset values. Key held after reset release → capture 4 edges after PRESS_WAIT re-entry.
- **Count boundary:** 256 legal presses → `scan_count`=0 without `UPC_SCANNER_SAT_EN`; 255 with it defined.

Source files
------------

// File: rtl/upc_scanner.sv
// UPC scan front end: synchronizes switches, debounces the scan key, and captures one legal code
// per clean press. Optional macro UPC_SCANNER_SAT_EN makes scan_count saturate instead of wrap.
module upc_scanner #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] sw,
    input  logic       key_n,
    output logic [2:0] bcd,
    output logic       valid,
    output logic       err,
    output logic [7:0] scan_count
);

    typedef enum logic [1:0] {StIdle, StPressWait, StHeld, StReleaseWait} state_e;

    localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_key_meta, r_key_s;
    logic [2:0]       r_sw_meta, r_sw_s;
    state_e           r_state, w_state_next;
    logic [CNT_W-1:0] r_cnt, w_cnt_next;
    logic             w_capture;
    logic             w_legal;
    logic [2:0]       r_bcd;
    logic             r_valid, r_err;
    logic [7:0]       r_scan_count;

    // Key synchronizer idles high so reset never looks like a press
    always_ff @(posedge clk) begin
        if (reset) begin
            r_key_meta <= 1'b1;
            r_key_s    <= 1'b1;
            r_sw_meta  <= 3'd0;
            r_sw_s     <= 3'd0;
        end else begin
            r_key_meta <= key_n;
            r_key_s    <= r_key_meta;
            r_sw_meta  <= sw;
            r_sw_s     <= r_sw_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= StIdle;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_capture    = 1'b0;
        case (r_state)
            StIdle: begin
                if (!r_key_s) begin
                    w_state_next = StPressWait;
                    w_cnt_next   = '0;
                end
            end
            StPressWait: begin
                if (r_key_s) begin
                    w_state_next = StIdle;
                    w_cnt_next   = '0;
                end else if (r_cnt == CntLast) begin
                    w_capture    = 1'b1;
                    w_state_next = StHeld;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            StHeld: begin
                if (r_key_s) begin
                    w_state_next = StReleaseWait;
                    w_cnt_next   = '0;
                end
            end
            StReleaseWait: begin
                if (!r_key_s) begin
                    w_state_next = StHeld;
                    w_cnt_next   = '0;
                end else if (r_cnt == CntLast) begin
                    w_state_next = StIdle;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_next = StIdle;
                w_cnt_next   = '0;
            end
        endcase
    end

    // The display decoder has no glyph for codes 2 and 7
    assign w_legal = (r_sw_s != 3'd2) && (r_sw_s != 3'd7);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_bcd        <= 3'd0;
            r_valid      <= 1'b0;
            r_err        <= 1'b0;
            r_scan_count <= 8'd0;
        end else if (w_capture) begin
            if (w_legal) begin
                r_bcd   <= r_sw_s;
                r_valid <= 1'b1;
                r_err   <= 1'b0;
`ifdef UPC_SCANNER_SAT_EN
                if (r_scan_count != 8'hFF) begin
                    r_scan_count <= r_scan_count + 8'd1;
                end
`else
                r_scan_count <= r_scan_count + 8'd1;
`endif
            end else begin
                r_err <= 1'b1;
            end
        end
    end

    assign bcd        = r_bcd;
    assign valid      = r_valid;
    assign err        = r_err;
    assign scan_count = r_scan_count;

endmodule

// File: tb/tb_upc_scanner.sv
// Scoreboard bench for upc_scanner (DEBOUNCE_CYCLES=4); expected output tuples and their
// arrival cycles are queued by the stimulus and checked by an independent monitor.
module tb_upc_scanner;

    localparam int unsigned Deb = 4;

    logic       clk;
    logic       reset;
    logic [2:0] sw;
    logic       key_n;
    logic [2:0] bcd;
    logic       valid;
    logic       err;
    logic [7:0] scan_count;

    upc_scanner #(.DEBOUNCE_CYCLES(Deb)) dut (
        .clk        (clk),
        .reset      (reset),
        .sw         (sw),
        .key_n      (key_n),
        .bcd        (bcd),
        .valid      (valid),
        .err        (err),
        .scan_count (scan_count)
    );

    typedef struct {
        logic [12:0] t;
        int          cyc;
    } exp_s;

    exp_s        q[$];
    logic [12:0] pq[$];
    logic [12:0] m_t;
    logic [12:0] w_now;
    int          cyc;
    int          checks;
    int          failures;
    bit          mon_en;
    bit          done;

    assign w_now = {bcd, valid, err, scan_count};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference behaviour of one debounced capture of code v
    function automatic logic [12:0] apply(input logic [12:0] cur, input logic [2:0] v);
        logic [2:0] b;
        logic       vl, e;
        logic [7:0] c;
        {b, vl, e, c} = cur;
        if (v == 3'd2 || v == 3'd7) begin
            e = 1'b1;
        end else begin
            b  = v;
            vl = 1'b1;
            e  = 1'b0;
`ifdef UPC_SCANNER_SAT_EN
            if (c != 8'd255) c = c + 8'd1;
`else
            c = c + 8'd1;
`endif
        end
        return {b, vl, e, c};
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_tuple(input logic [12:0] t, input int at);
        exp_s e;
        if (t != m_t) begin
            e.t   = t;
            e.cyc = at;
            q.push_back(e);
        end
        m_t = t;
    endtask

    task automatic probe(input logic [12:0] t);
        pq.push_back(t);
    endtask

    // Key falls after edge c; capture lands on edge c+7 (sync 2 + IDLE->PW + 4 debounce)
    task automatic press(input logic [2:0] v, input int hold);
        sw = v;
        step(3);
        key_n = 1'b0;
        expect_tuple(apply(m_t, v), cyc + 7);
        step(hold);
        key_n = 1'b1;
        step(8);
    endtask

    // Monitor: sole owner of the check counters
    initial begin
        logic [12:0] prev;
        logic [12:0] pt;
        exp_s        e;
        checks   = 0;
        failures = 0;
        prev     = '0;
        forever begin
            @(negedge clk);
            if (pq.size() != 0) begin
                pt = pq.pop_front();
                checks++;
                if (w_now !== pt) begin
                    failures++;
                    $display("FAIL probe cyc=%0d got=%h required=%h", cyc, w_now, pt);
                end
            end
            if (mon_en && w_now !== prev) begin
                checks++;
                if (q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_change cyc=%0d got=%h required=no change",
                             cyc, w_now);
                end else begin
                    e = q.pop_front();
                    if (w_now !== e.t || cyc != e.cyc) begin
                        failures++;
                        $display("FAIL capture got=%h@%0d required=%h@%0d",
                                 w_now, cyc, e.t, e.cyc);
                    end
                end
            end
            prev = w_now;
            if (done) begin
                checks++;
                if (q.size() != 0) begin
                    failures++;
                    $display("FAIL missing_updates got=%0d pending required=0", q.size());
                end
                $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
                $finish;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL timeout got=running required=finished");
        $fatal(1);
    end

    initial begin
        int c;
        cyc    = 0;
        mon_en = 1'b0;
        done   = 1'b0;
        m_t    = '0;
        // Reset with key down and a legal code present
        reset  = 1'b1;
        key_n  = 1'b0;
        sw     = 3'd5;
        step(1);
        probe(13'd0);
        reset = 1'b0;
        key_n = 1'b1;
        step(4);
        mon_en = 1'b1;

        // Clean press of 3; switch moves to 6 while held
        sw = 3'd3;
        step(3);
        key_n = 1'b0;
        expect_tuple(apply(m_t, 3'd3), cyc + 7);
        step(10);
        sw = 3'd6;
        step(10);
        probe({3'd3, 1'b1, 1'b0, 8'd1});
        key_n = 1'b1;
        step(8);

        // Press bounce: 3 low / 1 high never debounces
        sw = 3'd1;
        step(3);
        repeat (10) begin
            key_n = 1'b0;
            step(3);
            key_n = 1'b1;
            step(1);
        end
        step(8);
        probe({3'd3, 1'b1, 1'b0, 8'd1});

        // Release bounce inside RELEASE_WAIT must not recapture
        sw = 3'd4;
        step(3);
        key_n = 1'b0;
        expect_tuple(apply(m_t, 3'd4), cyc + 7);
        step(8);
        sw = 3'd0;
        key_n = 1'b1;
        step(3);
        key_n = 1'b0;
        step(2);
        key_n = 1'b1;
        step(10);
        probe({3'd4, 1'b1, 1'b0, 8'd2});

        // Illegal / legal / illegal
        press(3'd7, 8);
        probe({3'd4, 1'b1, 1'b1, 8'd2});
        press(3'd5, 8);
        probe({3'd5, 1'b1, 1'b0, 8'd3});
        press(3'd2, 8);
        probe({3'd5, 1'b1, 1'b1, 8'd3});

        // Reset two cycles into PRESS_WAIT, key kept down through release of reset
        sw = 3'd6;
        step(3);
        key_n = 1'b0;
        c = cyc;
        step(3);
        reset = 1'b1;
        expect_tuple(13'd0, c + 4);
        step(1);
        reset = 1'b0;
        expect_tuple(apply(m_t, 3'd6), c + 11);
        step(10);
        probe({3'd6, 1'b1, 1'b0, 8'd1});
        key_n = 1'b1;
        step(8);

        // Count boundary: 256 legal presses from reset
        reset = 1'b1;
        expect_tuple(13'd0, cyc + 1);
        step(1);
        reset = 1'b0;
        step(3);
        for (int i = 0; i < 256; i++) begin
            press((i % 2 == 1) ? 3'd4 : 3'd1, 8);
        end
`ifdef UPC_SCANNER_SAT_EN
        probe({3'd4, 1'b1, 1'b0, 8'd255});
`else
        probe({3'd4, 1'b1, 1'b0, 8'd0});
`endif
        step(4);
        done = 1'b1;
    end

endmodule
